// File: rtl/airlock_sequencer.sv
// Automatic airlock sequencer: arrival/departure fill-door-drain-door sequences with
// ramped pressure, one-deep request queue, abort from FILL and a door-open watchdog fault.
module airlock_sequencer #(
  parameter int unsigned P_MAX        = 9,
  parameter int unsigned STEP_CYCLES  = 4,
  parameter int unsigned DOOR_TIMEOUT = 64,
  localparam int unsigned PW          = $clog2(P_MAX + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          arrive,
  input  logic          depart,
  input  logic          clear,
  input  logic          abort,
  output logic [PW-1:0] pressure,
  output logic          outer_open,
  output logic          inner_open,
  output logic [2:0]    state,
  output logic          busy,
  output logic          done,
  output logic          aborted,
  output logic          fault
);

  localparam int unsigned SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int unsigned TW = $clog2(DOOR_TIMEOUT);

  localparam logic [SW-1:0] StepLast = SW'(STEP_CYCLES - 1);
  localparam logic [TW-1:0] TmoLast  = TW'(DOOR_TIMEOUT - 1);
  localparam logic [PW-1:0] PLast    = PW'(P_MAX - 1);
  localparam logic [PW-1:0] POne     = PW'(1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFill  = 3'd1,
    StOuter = 3'd2,
    StDrain = 3'd3,
    StInner = 3'd4,
    StFault = 3'd7
  } state_e;

  typedef enum logic {
    DirArr = 1'b0,
    DirDep = 1'b1
  } dir_e;

  state_e        state_q, state_d;
  dir_e          dir_q, dir_d;
  logic [PW-1:0] pressure_q, pressure_d;
  logic [SW-1:0] step_q, step_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          abrt_q, abrt_d;
  logic          pend_arr_q, pend_arr_d;
  logic          pend_dep_q, pend_dep_d;
  logic          done_q, done_d;
  logic          aborted_q, aborted_d;
  logic          drain_exit;

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    pressure_d = pressure_q;
    step_d     = step_q;
    tmo_d      = tmo_q;
    abrt_d     = abrt_q;
    pend_arr_d = pend_arr_q;
    pend_dep_d = pend_dep_q;
    done_d     = 1'b0;
    aborted_d  = 1'b0;
    drain_exit = 1'b0;

    // Requests arriving mid-sequence are queued, one bit per type.
    if (state_q != StIdle && state_q != StFault) begin
      pend_arr_d = pend_arr_q | arrive;
      pend_dep_d = pend_dep_q | depart;
    end

    case (state_q)
      StIdle: begin
        abrt_d = 1'b0;
        if (pend_arr_q || arrive) begin
          state_d    = StFill;
          dir_d      = DirArr;
          pend_arr_d = 1'b0;
          pend_dep_d = pend_dep_q | depart;
        end else if (pend_dep_q || depart) begin
          state_d    = StInner;
          dir_d      = DirDep;
          pend_dep_d = 1'b0;
        end
      end
      StFill: begin
        if (abort) begin
          state_d = StDrain;
          abrt_d  = 1'b1;
        end else if (step_q == StepLast) begin
          step_d     = '0;
          pressure_d = pressure_q + 1'b1;
          if (pressure_q == PLast) state_d = StOuter;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      StDrain: begin
        // An abort at zero pressure has nothing to drain.
        if (pressure_q == '0) begin
          drain_exit = 1'b1;
        end else if (step_q == StepLast) begin
          step_d     = '0;
          pressure_d = pressure_q - 1'b1;
          if (pressure_q == POne) drain_exit = 1'b1;
        end else begin
          step_d = step_q + 1'b1;
        end
        if (drain_exit) begin
          if (abrt_q) begin
            state_d   = StIdle;
            aborted_d = 1'b1;
          end else if (dir_q == DirArr) begin
            state_d = StInner;
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      StOuter: begin
        if (clear) state_d = StDrain;
        else if (tmo_q == TmoLast) state_d = StFault;
        else tmo_d = tmo_q + 1'b1;
      end
      StInner: begin
        if (clear) begin
          if (dir_q == DirArr) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d = StFill;
          end
        end else if (tmo_q == TmoLast) begin
          state_d = StFault;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StFault: begin
        pend_arr_d = 1'b0;
        pend_dep_d = 1'b0;
      end
      default: state_d = StFault;
    endcase

    // Ramp and watchdog counters restart on every state entry.
    if (state_d != state_q) begin
      step_d = '0;
      tmo_d  = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      dir_q      <= DirArr;
      pressure_q <= '0;
      step_q     <= '0;
      tmo_q      <= '0;
      abrt_q     <= 1'b0;
      pend_arr_q <= 1'b0;
      pend_dep_q <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      pressure_q <= pressure_d;
      step_q     <= step_d;
      tmo_q      <= tmo_d;
      abrt_q     <= abrt_d;
      pend_arr_q <= pend_arr_d;
      pend_dep_q <= pend_dep_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
    end
  end

  assign state      = state_q;
  assign pressure   = pressure_q;
  assign busy       = (state_q != StIdle);
  assign outer_open = (state_q == StOuter);
  assign inner_open = (state_q == StInner);
  assign fault      = (state_q == StFault);
  assign done       = done_q;
  assign aborted    = aborted_q;

endmodule

// File: tb/tb_airlock_sequencer.sv
// Directed self-checking bench for airlock_sequencer (P_MAX=4, STEP_CYCLES=3, DOOR_TIMEOUT=8).
module tb_airlock_sequencer;

  localparam int unsigned PM = 4;
  localparam int unsigned SC = 3;
  localparam int unsigned DT = 8;
  localparam int unsigned PW = $clog2(PM + 1);

  logic          clock;
  logic          reset;
  logic          arrive, depart, clear, abort;
  logic [PW-1:0] pressure;
  logic          outer_open, inner_open, busy, done, aborted, fault;
  logic [2:0]    state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  airlock_sequencer #(
    .P_MAX       (PM),
    .STEP_CYCLES (SC),
    .DOOR_TIMEOUT(DT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .arrive    (arrive),
    .depart    (depart),
    .clear     (clear),
    .abort     (abort),
    .pressure  (pressure),
    .outer_open(outer_open),
    .inner_open(inner_open),
    .state     (state),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .fault     (fault)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Cycle n is the interval just after edge n; inputs and samples sit 1 time unit past the edge.
  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset();
    arrive = 1'b0; depart = 1'b0; clear = 1'b0; abort = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic pulse_clear_at(input int n);
    run_to(n);
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL rst_state: got %0d want 0", state); end
    checks++; if (pressure !== '0) begin errors++; $display("FAIL rst_pressure: got %0d want 0", pressure); end
    checks++; if ({outer_open, inner_open} !== 2'b00) begin
      errors++; $display("FAIL rst_doors: got %b want 00", {outer_open, inner_open}); end
    checks++; if ({busy, done, aborted, fault} !== 4'b0000) begin
      errors++; $display("FAIL rst_flags: got %b want 0000", {busy, done, aborted, fault}); end
  endtask

  task automatic test_arrival();
    do_reset();
    arrive = 1'b1;
    tick();
    arrive = 1'b0;
    checks++; if (state !== 3'd1 || busy !== 1'b1) begin
      errors++; $display("FAIL arr_fill_entry: state=%0d busy=%b want 1/1", state, busy); end
    run_to(3);
    checks++; if (pressure !== 3'd0) begin errors++; $display("FAIL arr_p_c3: got %0d want 0", pressure); end
    run_to(4);
    checks++; if (pressure !== 3'd1) begin errors++; $display("FAIL arr_p_c4: got %0d want 1", pressure); end
    run_to(12);
    checks++; if (state !== 3'd1 || pressure !== 3'd3) begin
      errors++; $display("FAIL arr_c12: state=%0d p=%0d want 1/3", state, pressure); end
    run_to(13);
    checks++; if (state !== 3'd2 || pressure !== 3'd4 || outer_open !== 1'b1) begin
      errors++; $display("FAIL arr_outer: state=%0d p=%0d outer=%b want 2/4/1", state, pressure, outer_open); end
    run_to(20);
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL arr_outer_c20: got %0d want 2", state); end
    pulse_clear_at(20);
    checks++; if (state !== 3'd3 || outer_open !== 1'b0) begin
      errors++; $display("FAIL arr_drain: state=%0d outer=%b want 3/0", state, outer_open); end
    run_to(24);
    checks++; if (pressure !== 3'd3) begin errors++; $display("FAIL arr_p_c24: got %0d want 3", pressure); end
    run_to(32);
    checks++; if (state !== 3'd3 || pressure !== 3'd1) begin
      errors++; $display("FAIL arr_c32: state=%0d p=%0d want 3/1", state, pressure); end
    run_to(33);
    checks++; if (state !== 3'd4 || pressure !== 3'd0 || inner_open !== 1'b1) begin
      errors++; $display("FAIL arr_inner: state=%0d p=%0d inner=%b want 4/0/1", state, pressure, inner_open); end
    pulse_clear_at(35);
    checks++; if (state !== 3'd0 || done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL arr_done: state=%0d done=%b busy=%b want 0/1/0", state, done, busy); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL arr_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_departure();
    int both, done_cnt, done_at, outer_at;
    logic [PW-1:0] outer_p;
    both = 0; done_cnt = 0; done_at = -1; outer_at = -1; outer_p = '0;
    do_reset();
    depart = 1'b1;
    tick();
    depart = 1'b0;
    checks++; if (state !== 3'd4 || inner_open !== 1'b1) begin
      errors++; $display("FAIL dep_inner: state=%0d inner=%b want 4/1", state, inner_open); end
    while (cyc < 32) begin
      if (inner_open && outer_open) both++;
      if (done) begin done_cnt++; done_at = cyc; end
      if (outer_open && outer_at < 0) begin outer_at = cyc; outer_p = pressure; end
      clear = (cyc == 2 || cyc == 16);
      tick();
    end
    clear = 1'b0;
    checks++; if (outer_at !== 15 || outer_p !== 3'd4) begin
      errors++; $display("FAIL dep_outer: cycle=%0d p=%0d want 15/4", outer_at, outer_p); end
    checks++; if (done_cnt !== 1 || done_at !== 29) begin
      errors++; $display("FAIL dep_done: count=%0d cycle=%0d want 1/29", done_cnt, done_at); end
    checks++; if (both !== 0) begin errors++; $display("FAIL dep_doors: both-open cycles=%0d want 0", both); end
  endtask

  task automatic test_abort();
    do_reset();
    arrive = 1'b1;
    tick();
    arrive = 1'b0;
    run_to(7);
    checks++; if (state !== 3'd1 || pressure !== 3'd2) begin
      errors++; $display("FAIL abt_pre: state=%0d p=%0d want 1/2", state, pressure); end
    abort = 1'b1;
    tick();
    checks++; if (state !== 3'd3 || pressure !== 3'd2) begin
      errors++; $display("FAIL abt_drain: state=%0d p=%0d want 3/2", state, pressure); end
    run_to(13);
    checks++; if (state !== 3'd3 || pressure !== 3'd1) begin
      errors++; $display("FAIL abt_c13: state=%0d p=%0d want 3/1", state, pressure); end
    tick();
    checks++; if (state !== 3'd0 || aborted !== 1'b1 || done !== 1'b0 || pressure !== 3'd0) begin
      errors++; $display("FAIL abt_idle: state=%0d aborted=%b done=%b p=%0d want 0/1/0/0",
                         state, aborted, done, pressure); end
    abort = 1'b0;
    tick();
    checks++; if (aborted !== 1'b0 || state !== 3'd0) begin
      errors++; $display("FAIL abt_pulse: aborted=%b state=%0d want 0/0", aborted, state); end
  endtask

  task automatic test_timeout();
    do_reset();
    arrive = 1'b1;
    tick();
    arrive = 1'b0;
    run_to(13);
    abort = 1'b1;
    run_to(20);
    checks++; if (state !== 3'd2 || outer_open !== 1'b1) begin
      errors++; $display("FAIL tmo_last: state=%0d outer=%b want 2/1", state, outer_open); end
    tick();
    checks++; if (state !== 3'd7 || fault !== 1'b1 || {outer_open, inner_open} !== 2'b00
                  || pressure !== 3'd4) begin
      errors++; $display("FAIL tmo_fault: state=%0d fault=%b doors=%b p=%0d want 7/1/00/4",
                         state, fault, {outer_open, inner_open}, pressure); end
    abort = 1'b0; arrive = 1'b1; depart = 1'b1; clear = 1'b1;
    run_to(25);
    checks++; if (state !== 3'd7 || pressure !== 3'd4 || fault !== 1'b1) begin
      errors++; $display("FAIL tmo_sticky: state=%0d p=%0d fault=%b want 7/4/1", state, pressure, fault); end
    do_reset();
    checks++; if (state !== 3'd0 || pressure !== 3'd0 || {busy, done, aborted, fault} !== 4'b0000) begin
      errors++; $display("FAIL tmo_reset: state=%0d p=%0d flags=%b want 0/0/0000",
                         state, pressure, {busy, done, aborted, fault}); end
    tick();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL tmo_pending: got %0d want 0", state); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    arrive = 1'b1; depart = 1'b1;
    tick();
    arrive = 1'b0; depart = 1'b0;
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL b2b_arr_first: got %0d want 1", state); end
    pulse_clear_at(13);
    pulse_clear_at(26);
    checks++; if (state !== 3'd0 || done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_gap: state=%0d done=%b busy=%b want 0/1/0", state, done, busy); end
    pulse_clear_at(28);
    run_to(30); arrive = 1'b1; tick(); arrive = 1'b0;
    run_to(32); arrive = 1'b1; tick(); arrive = 1'b0;
    pulse_clear_at(41);
    run_to(54);
    checks++; if (state !== 3'd0 || done !== 1'b1) begin
      errors++; $display("FAIL b2b_dep_done: state=%0d done=%b want 0/1", state, done); end
    tick();
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL b2b_merged_start: got %0d want 1", state); end
    pulse_clear_at(67);
    pulse_clear_at(80);
    checks++; if (state !== 3'd0 || done !== 1'b1) begin
      errors++; $display("FAIL b2b_third_done: state=%0d done=%b want 0/1", state, done); end
    tick();
    checks++; if (state !== 3'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_merged_once: state=%0d busy=%b want 0/0", state, busy); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    arrive = 1'b1;
    tick();
    arrive = 1'b0;
    run_to(3); depart = 1'b1; tick(); depart = 1'b0;
    pulse_clear_at(13);
    run_to(17);
    checks++; if (state !== 3'd3 || pressure !== 3'd3) begin
      errors++; $display("FAIL rmid_pre: state=%0d p=%0d want 3/3", state, pressure); end
    reset = 1'b1;
    tick();
    checks++; if (state !== 3'd0 || pressure !== 3'd0 || done !== 1'b0 || aborted !== 1'b0) begin
      errors++; $display("FAIL rmid_after: state=%0d p=%0d done=%b aborted=%b want 0/0/0/0",
                         state, pressure, done, aborted); end
    reset = 1'b0;
    tick();
    tick();
    checks++; if (state !== 3'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL rmid_pending: state=%0d busy=%b want 0/0", state, busy); end
  endtask

  initial begin
    reset = 1'b1; arrive = 1'b0; depart = 1'b0; clear = 1'b0; abort = 1'b0;
    test_reset();
    test_arrival();
    test_departure();
    test_abort();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
